// File: rtl/tube_sync_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tube_sync_mc : single-clock multi-channel Tube, host<->parasite FIFOs.    |
// | Optional macro TUBE_SYNC_MC_LEVEL_EN: status low bits report FIFO level.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module tube_sync_mc_fifo #(
  parameter int SIZE = 4,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic          ovf_clr,
  input  logic [7:0]    wdata,
  input  logic [CW-1:0] cap,
  output logic [7:0]    rdata,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  localparam int PW = $clog2(SIZE);

  logic [7:0]    mem_q [SIZE];
  logic [7:0]    mem_d [SIZE];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop && (cnt_q != '0) && !flush;
    // A pop in the same cycle frees a slot, so the push is judged against the post-pop count.
    push_ok = push && ((cnt_q - CW'(pop_ok)) < cap);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ovf_d   = ovf_q;
    rdata   = pop_ok ? mem_q[rd_q] : 8'h00;
    if (ovf_clr) ovf_d = 1'b0;
    if (push_ok) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + PW'(1);
    end else if (push) begin
      ovf_d = 1'b1;
    end
    if (pop_ok) rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

module tube_sync_mc #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int R3_CH  = 2,
  parameter int AW     = 4
) (
  input  logic          phi2,
  input  logic          rst,
  input  logic [AW-1:0] h_addr,
  input  logic          h_cs,
  input  logic          h_we,
  input  logic [7:0]    h_wdata,
  output logic [7:0]    h_rdata,
  input  logic [AW-1:0] p_addr,
  input  logic          p_cs,
  input  logic          p_we,
  input  logic [7:0]    p_wdata,
  output logic [7:0]    p_rdata,
  output logic          h_irq_b,
  output logic          p_irq_b,
  output logic          p_nmi_b,
  output logic          p_rst_b
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CHW = AW - 1;

  localparam int F_T = 6;
  localparam int F_P = 5;
  localparam int F_V = 4;
  localparam int F_M = 3;
  localparam int F_J = 2;
  localparam int F_I = 1;
  localparam int F_Q = 0;

  logic [6:0]        flags_q, flags_d;
  logic [7:0]        h_rdata_q, h_rdata_d, p_rdata_q, p_rdata_d;
  logic              h_irq_q, h_irq_d, p_irq_q, p_irq_d, p_nmi_q, p_nmi_d;

  logic [CHW-1:0]    h_ch, p_ch;
  logic [NUM_CH-1:0] h_sel, p_sel;
  logic [NUM_CH-1:0] h2p_push, h2p_pop, p2h_push, p2h_pop;
  logic [NUM_CH-1:0] h2p_oclr, p2h_oclr, h2p_ovf, p2h_ovf, h2p_full, p2h_full;
  logic [CW-1:0]     h2p_cnt [NUM_CH];
  logic [CW-1:0]     p2h_cnt [NUM_CH];
  logic [CW-1:0]     cap     [NUM_CH];
  logic [7:0]        h2p_head [NUM_CH];
  logic [7:0]        p2h_head [NUM_CH];
  logic [CW-1:0]     r3_cap;
  logic              n_flag;
  logic [7:0]        h_stat, p_stat, h_pop_byte, p_pop_byte;

  assign h_ch   = h_addr[AW-1:1];
  assign p_ch   = p_addr[AW-1:1];
  assign r3_cap = flags_q[F_V] ? CW'(2) : CW'(1);

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam int SIZE = (k == R3_CH) ? 2 : DEPTH;

      if (k == R3_CH) begin : g_r3
        assign cap[k] = r3_cap;
      end else begin : g_std
        assign cap[k] = CW'(DEPTH);
      end

      assign h_sel[k]    = h_cs && (int'(h_ch) == k);
      assign p_sel[k]    = p_cs && (int'(p_ch) == k);
      assign h2p_push[k] = h_sel[k] &&  h_we &&  h_addr[0];
      assign p2h_pop[k]  = h_sel[k] && !h_we &&  h_addr[0];
      assign p2h_oclr[k] = h_sel[k] && !h_we && !h_addr[0];
      assign p2h_push[k] = p_sel[k] &&  p_we &&  p_addr[0];
      assign h2p_pop[k]  = p_sel[k] && !p_we &&  p_addr[0];
      assign h2p_oclr[k] = p_sel[k] && !p_we && !p_addr[0];
      assign h2p_full[k] = h2p_cnt[k] >= cap[k];
      assign p2h_full[k] = p2h_cnt[k] >= cap[k];

      tube_sync_mc_fifo #(.SIZE(SIZE), .CW(CW)) u_h2p (
        .clk     (phi2),
        .rst     (rst),
        .flush   (flags_q[F_T]),
        .push    (h2p_push[k]),
        .pop     (h2p_pop[k]),
        .ovf_clr (h2p_oclr[k]),
        .wdata   (h_wdata),
        .cap     (cap[k]),
        .rdata   (h2p_head[k]),
        .cnt     (h2p_cnt[k]),
        .ovf     (h2p_ovf[k])
      );

      tube_sync_mc_fifo #(.SIZE(SIZE), .CW(CW)) u_p2h (
        .clk     (phi2),
        .rst     (rst),
        .flush   (flags_q[F_T]),
        .push    (p2h_push[k]),
        .pop     (p2h_pop[k]),
        .ovf_clr (p2h_oclr[k]),
        .wdata   (p_wdata),
        .cap     (cap[k]),
        .rdata   (p2h_head[k]),
        .cnt     (p2h_cnt[k]),
        .ovf     (p2h_ovf[k])
      );
    end
  endgenerate

`ifdef TUBE_SYNC_MC_LEVEL_EN
  function automatic logic [4:0] level(input logic [CW-1:0] c);
    logic [5:0] c6;
    c6    = 6'(c);
    level = (c6 > 6'd31) ? 5'd31 : c6[4:0];
  endfunction
`endif

  // N: the R3 parasite "not ready" indication that also drives NMI.
  always_comb begin
    if (flags_q[F_V]) n_flag = (h2p_cnt[R3_CH] == CW'(2)) || (p2h_cnt[R3_CH] == '0);
    else              n_flag = (h2p_cnt[R3_CH] != '0)     || (p2h_cnt[R3_CH] == '0);
  end

  always_comb begin
    h_stat     = 8'h00;
    p_stat     = 8'h00;
    h_pop_byte = 8'h00;
    p_pop_byte = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(h_ch) == k) begin
        h_stat[7]  = p2h_cnt[k] != '0;
        h_stat[6]  = !h2p_full[k];
`ifdef TUBE_SYNC_MC_LEVEL_EN
        h_stat[5:0] = (k == 0) ? flags_q[5:0] : {p2h_ovf[k], level(p2h_cnt[k])};
`else
        h_stat[5:0] = (k == 0) ? flags_q[5:0] : {p2h_ovf[k], 5'b11111};
`endif
        h_pop_byte = p2h_head[k];
      end
      if (int'(p_ch) == k) begin
        p_stat[7]  = (k == R3_CH) ? n_flag : (h2p_cnt[k] != '0);
        p_stat[6]  = !p2h_full[k];
`ifdef TUBE_SYNC_MC_LEVEL_EN
        p_stat[5:0] = (k == 0) ? flags_q[5:0] : {h2p_ovf[k], level(h2p_cnt[k])};
`else
        p_stat[5:0] = (k == 0) ? flags_q[5:0] : {h2p_ovf[k], 5'b11111};
`endif
        p_pop_byte = h2p_head[k];
      end
    end
  end

  always_comb begin
    flags_d   = flags_q;
    h_rdata_d = h_rdata_q;
    p_rdata_d = p_rdata_q;
    // Each set bit in the write mask loads the S bit into that flag.
    if (h_cs && h_we && !h_addr[0] && (h_ch == '0)) begin
      for (int i = 0; i < 7; i++) begin
        if (h_wdata[i]) flags_d[i] = h_wdata[7];
      end
    end
    if (h_cs && !h_we) h_rdata_d = h_addr[0] ? h_pop_byte : h_stat;
    if (p_cs && !p_we) p_rdata_d = p_addr[0] ? p_pop_byte : p_stat;

    h_irq_d = !(flags_q[F_Q] && (p2h_cnt[NUM_CH-1] != '0));
    p_irq_d = !((flags_q[F_I] && (h2p_cnt[0] != '0)) ||
                (flags_q[F_J] && (h2p_cnt[NUM_CH-1] != '0)));
    p_nmi_d = !(flags_q[F_M] && n_flag);
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      flags_q   <= '0;
      h_rdata_q <= 8'h00;
      p_rdata_q <= 8'h00;
      h_irq_q   <= 1'b1;
      p_irq_q   <= 1'b1;
      p_nmi_q   <= 1'b1;
    end else begin
      flags_q   <= flags_d;
      h_rdata_q <= h_rdata_d;
      p_rdata_q <= p_rdata_d;
      h_irq_q   <= h_irq_d;
      p_irq_q   <= p_irq_d;
      p_nmi_q   <= p_nmi_d;
    end
  end

  assign h_rdata = h_rdata_q;
  assign p_rdata = p_rdata_q;
  assign h_irq_b = h_irq_q;
  assign p_irq_b = p_irq_q;
  assign p_nmi_b = p_nmi_q;
  assign p_rst_b = !(rst || flags_q[F_P]);
endmodule

`default_nettype wire

// File: tb/tb_tube_sync_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tube_sync_mc : directed checks of tube_sync_mc (default parameters,    |
// | TUBE_SYNC_MC_LEVEL_EN undefined).                                         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_tube_sync_mc;
  logic       phi2 = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] h_addr = '0, p_addr = '0;
  logic       h_cs = 1'b0, h_we = 1'b0, p_cs = 1'b0, p_we = 1'b0;
  logic [7:0] h_wdata = '0, p_wdata = '0;
  logic [7:0] h_rdata, p_rdata;
  logic       h_irq_b, p_irq_b, p_nmi_b, p_rst_b;

  int checks = 0;
  int errors = 0;

  tube_sync_mc #(.NUM_CH(4), .DEPTH(4), .R3_CH(2), .AW(4)) dut (
    .phi2    (phi2),
    .rst     (rst),
    .h_addr  (h_addr),
    .h_cs    (h_cs),
    .h_we    (h_we),
    .h_wdata (h_wdata),
    .h_rdata (h_rdata),
    .p_addr  (p_addr),
    .p_cs    (p_cs),
    .p_we    (p_we),
    .p_wdata (p_wdata),
    .p_rdata (p_rdata),
    .h_irq_b (h_irq_b),
    .p_irq_b (p_irq_b),
    .p_nmi_b (p_nmi_b),
    .p_rst_b (p_rst_b)
  );

  always #5 phi2 = ~phi2;

  typedef struct {
    bit         par;
    bit         we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge phi2);
  endtask

  // One strobe cycle; read data is sampled on the falling edge after the capturing edge.
  task automatic acc(input bit par, input bit we, input logic [3:0] addr,
                     input logic [7:0] data, output logic [7:0] rd);
    @(negedge phi2);
    if (par) begin p_cs = 1'b1; p_we = we; p_addr = addr; p_wdata = data; end
    else     begin h_cs = 1'b1; h_we = we; h_addr = addr; h_wdata = data; end
    @(negedge phi2);
    rd   = par ? p_rdata : h_rdata;
    h_cs = 1'b0;
    p_cs = 1'b0;
  endtask

  task automatic hw(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] x;
    acc(1'b0, 1'b1, a, d, x);
  endtask

  task automatic pw(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] x;
    acc(1'b1, 1'b1, a, d, x);
  endtask

  task automatic hr(input string name, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] x;
    acc(1'b0, 1'b0, a, 8'h00, x);
    chk(name, x, exp);
  endtask

  task automatic pr(input string name, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] x;
    acc(1'b1, 1'b0, a, 8'h00, x);
    chk(name, x, exp);
  endtask

  // Host write and parasite read of the same data register in one cycle.
  task automatic both(input string name, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] exp);
    @(negedge phi2);
    h_cs = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
    p_cs = 1'b1; p_we = 1'b0; p_addr = a;
    @(negedge phi2);
    h_cs = 1'b0; p_cs = 1'b0;
    chk(name, p_rdata, exp);
  endtask

  vec_t vt [18];

  initial begin
    vt[0]  = '{0, 1, 4'h0, 8'h92, 8'h00};
    vt[1]  = '{0, 0, 4'h0, 8'h00, 8'h52};
    vt[2]  = '{0, 1, 4'h0, 8'h12, 8'h00};
    vt[3]  = '{0, 0, 4'h0, 8'h00, 8'h40};
    vt[4]  = '{0, 1, 4'h3, 8'hA1, 8'h00};
    vt[5]  = '{0, 1, 4'h3, 8'hA2, 8'h00};
    vt[6]  = '{0, 1, 4'h3, 8'hA3, 8'h00};
    vt[7]  = '{0, 1, 4'h3, 8'hA4, 8'h00};
    vt[8]  = '{0, 1, 4'h3, 8'hA5, 8'h00};
    vt[9]  = '{0, 0, 4'h2, 8'h00, 8'h1F};
    vt[10] = '{1, 0, 4'h2, 8'h00, 8'hFF};
    vt[11] = '{1, 0, 4'h2, 8'h00, 8'hDF};
    vt[12] = '{1, 0, 4'h3, 8'h00, 8'hA1};
    vt[13] = '{1, 0, 4'h3, 8'h00, 8'hA2};
    vt[14] = '{1, 0, 4'h3, 8'h00, 8'hA3};
    vt[15] = '{1, 0, 4'h3, 8'h00, 8'hA4};
    vt[16] = '{1, 0, 4'h3, 8'h00, 8'h00};
    vt[17] = '{1, 0, 4'h2, 8'h00, 8'h5F};

    // Reset state
    idle(3);
    chk("rst_h_rdata", h_rdata, 8'h00);
    chk("rst_p_rdata", p_rdata, 8'h00);
    chk("rst_h_irq_b", {7'd0, h_irq_b}, 8'h01);
    chk("rst_p_irq_b", {7'd0, p_irq_b}, 8'h01);
    chk("rst_p_nmi_b", {7'd0, p_nmi_b}, 8'h01);
    chk("rst_p_rst_b", {7'd0, p_rst_b}, 8'h00);
    rst = 1'b0;
    idle(1);
    chk("rel_p_rst_b", {7'd0, p_rst_b}, 8'h01);

    // Flags and ch1 fill/overflow table
    for (int i = 0; i < 18; i++) begin
      logic [7:0] x;
      acc(vt[i].par, vt[i].we, vt[i].addr, vt[i].data, x);
      if (!vt[i].we) chk($sformatf("vec%0d", i), x, vt[i].exp);
    end

    // Simultaneous push/pop on a full FIFO, then on an empty one
    hw(4'h3, 8'hB1); hw(4'h3, 8'hB2); hw(4'h3, 8'hB3); hw(4'h3, 8'hB4);
    both("pp_full_pop", 4'h3, 8'hB5, 8'hB1);
    pr("pp_full_nofv", 4'h2, 8'hDF);
    hr("pp_full_still", 4'h2, 8'h1F);
    pr("pp_b2", 4'h3, 8'hB2);
    pr("pp_b3", 4'h3, 8'hB3);
    pr("pp_b4", 4'h3, 8'hB4);
    pr("pp_b5", 4'h3, 8'hB5);
    pr("pp_empty", 4'h3, 8'h00);
    both("pp_empty_pop", 4'h3, 8'hE1, 8'h00);
    pr("pp_empty_push", 4'h3, 8'hE1);

    // R3 channel: one-byte mode and NMI
    hw(4'h0, 8'h88);
    hw(4'h5, 8'h5A);
    chk("nmi_low", {7'd0, p_nmi_b}, 8'h00);
    pr("r3_pstat_n", 4'h4, 8'hDF);
    hr("r3_hstat_full1", 4'h4, 8'h1F);
    hw(4'h5, 8'h5B);
    pr("r3_rd_5a", 4'h5, 8'h5A);
    pr("r3_rd_drop", 4'h5, 8'h00);
    idle(1);
    chk("nmi_stay_low", {7'd0, p_nmi_b}, 8'h00);
    pw(4'h5, 8'hC0);
    idle(1);
    chk("nmi_high", {7'd0, p_nmi_b}, 8'h01);

    // R3 two-byte mode, then clear V with two bytes queued
    hw(4'h0, 8'h90);
    hw(4'h5, 8'h61);
    hw(4'h5, 8'h62);
    hr("r3v_hstat_full2", 4'h4, 8'h9F);
    pr("r3v_pstat_n", 4'h4, 8'hFF);
    chk("r3v_nmi_low", {7'd0, p_nmi_b}, 8'h00);
    hw(4'h0, 8'h10);
    hr("r3_clrv_full", 4'h4, 8'h9F);
    pr("r3_clrv_rd61", 4'h5, 8'h61);
    hr("r3_clrv_full1", 4'h4, 8'h9F);
    pr("r3_clrv_rd62", 4'h5, 8'h62);
    hr("r3_clrv_nfull", 4'h4, 8'hDF);
    hr("r3_h_rd_c0", 4'h5, 8'hC0);
    hw(4'h0, 8'h08);

    // Host IRQ and soft reset
    hw(4'h0, 8'h81);
    pw(4'h7, 8'h77);
    chk("hirq_latency", {7'd0, h_irq_b}, 8'h01);
    idle(1);
    chk("hirq_low", {7'd0, h_irq_b}, 8'h00);
    hw(4'h0, 8'hC0);
    idle(2);
    chk("hirq_soft_rst", {7'd0, h_irq_b}, 8'h01);
    hr("soft_hstat3", 4'h6, 8'h5F);
    hw(4'h3, 8'hD1);
    pr("soft_push_drop", 4'h3, 8'h00);
    hw(4'h0, 8'h40);
    hw(4'h0, 8'hA0);
    chk("p_rst_b_low", {7'd0, p_rst_b}, 8'h00);
    hw(4'h0, 8'h21);
    chk("p_rst_b_high", {7'd0, p_rst_b}, 8'h01);

    // Parasite IRQ from ch0 (I) and last channel (J)
    hw(4'h0, 8'h86);
    hw(4'h1, 8'h11);
    idle(1);
    chk("pirq_i_low", {7'd0, p_irq_b}, 8'h00);
    pr("pirq_rd11", 4'h1, 8'h11);
    idle(1);
    chk("pirq_i_high", {7'd0, p_irq_b}, 8'h01);
    hw(4'h7, 8'h22);
    idle(1);
    chk("pirq_j_low", {7'd0, p_irq_b}, 8'h00);
    pr("pirq_rd22", 4'h7, 8'h22);
    hw(4'h0, 8'h06);

    // Reset in the middle of traffic
    hw(4'h0, 8'h8B);
    hw(4'h1, 8'h31); hw(4'h1, 8'h32); hw(4'h1, 8'h33);
    pw(4'h7, 8'h44);
    idle(1);
    chk("mid_hirq_low", {7'd0, h_irq_b}, 8'h00);
    chk("mid_pirq_low", {7'd0, p_irq_b}, 8'h00);
    chk("mid_nmi_low", {7'd0, p_nmi_b}, 8'h00);
    pr("mid_rd31", 4'h1, 8'h31);
    rst = 1'b1;
    idle(2);
    chk("mid_rst_p_rst_b", {7'd0, p_rst_b}, 8'h00);
    chk("mid_rst_h_rdata", h_rdata, 8'h00);
    chk("mid_rst_p_rdata", p_rdata, 8'h00);
    rst = 1'b0;
    idle(1);
    chk("mid_rel_hirq", {7'd0, h_irq_b}, 8'h01);
    chk("mid_rel_pirq", {7'd0, p_irq_b}, 8'h01);
    chk("mid_rel_nmi", {7'd0, p_nmi_b}, 8'h01);
    pr("mid_h2p_empty", 4'h1, 8'h00);
    hr("mid_hstat0", 4'h0, 8'h40);
    hr("mid_p2h_empty", 4'h7, 8'h00);
    pr("mid_pstat0", 4'h0, 8'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "testbench timeout");
  end
endmodule
`default_nettype wire
